store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 28 ++
 rtl/store_buffer.sv | 160 ++++++++++++++++
 tb/tb_store_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core-side and memory-side signal bundle for store_buffer
// slave modport is the buffer itself; master is the core/memory environment.
interface store_buffer_if;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrobe;
   logic        req_wen;
   logic        req_ren;
   logic [31:0] resp_rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrobe;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_addr, req_wdata, req_wstrobe, req_wen, req_ren, mem_ack, mem_rdata,
      output resp_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrobe
   );

   modport master (
      output req_addr, req_wdata, req_wstrobe, req_wen, req_ren, mem_ack, mem_rdata,
      input  resp_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrobe
   );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store FIFO draining to memory, loads bypass with conflict check
// Optional store-to-load forwarding of full-word entries when SB_FORWARD_EN is defined.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;

   state_t          state, state_nxt;
   logic [29:0]     ent_addr [DEPTH];
   logic [31:0]     ent_data [DEPTH];
   logic [3:0]      ent_strb [DEPTH];
   logic [PW-1:0]   head, tail, idx;
   logic [CW-1:0]   count;

   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [3:0]      mem_wstrobe_q, mem_wstrobe_d;
   logic [31:0]     rdata_q, rdata_d;

   logic            full, push, pop, load_pend, conflict, fwd_hit;
`ifdef SB_FORWARD_EN
   logic            fwd_ok;
   logic [31:0]     fwd_data;
`endif

   assign full      = (count == CW'(DEPTH));
   assign push      = sb.req_wen && !full;
   assign pop       = (state == WR) && sb.mem_ack;
   assign load_pend = sb.req_ren && !sb.req_wen;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      conflict = 1'b0;
      idx      = '0;
`ifdef SB_FORWARD_EN
      fwd_ok   = 1'b0;
      fwd_data = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((CW'(k) < count) && (ent_addr[idx] == sb.req_addr[31:2])) begin
            conflict = 1'b1;
`ifdef SB_FORWARD_EN
            fwd_ok   = (ent_strb[idx] == 4'hF);
            fwd_data = ent_data[idx];
`endif
         end
      end
   end

`ifdef SB_FORWARD_EN
   assign fwd_hit = rst && load_pend && fwd_ok && (state != RD) && (state != RD_DONE);
   assign sb.resp_rdata = fwd_hit ? fwd_data : rdata_q;
`else
   assign fwd_hit = 1'b0;
   assign sb.resp_rdata = rdata_q;
`endif

   always_comb begin
      sb.stall = 1'b0;
      if (!rst)
         sb.stall = 1'b0;
      else if (sb.req_wen)
         sb.stall = full;
      else if (sb.req_ren)
         sb.stall = (state != RD_DONE) && !fwd_hit;
   end

   always_comb begin
      state_nxt     = state;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_wstrobe_d = mem_wstrobe_q;
      rdata_d       = rdata_q;
      case (state)
         IDLE: begin
            if (load_pend && !fwd_hit && !conflict) begin
               state_nxt     = RD;
               mem_req_d     = 1'b1;
               mem_we_d      = 1'b0;
               mem_addr_d    = sb.req_addr;
               mem_wstrobe_d = 4'hF;
            end else if (count != '0) begin
               state_nxt     = WR;
               mem_req_d     = 1'b1;
               mem_we_d      = 1'b1;
               mem_addr_d    = {ent_addr[head], 2'b00};
               mem_wdata_d   = ent_data[head];
               mem_wstrobe_d = ent_strb[head];
            end
         end
         WR: begin
            if (sb.mem_ack) begin
               state_nxt = IDLE;
               mem_req_d = 1'b0;
            end
         end
         RD: begin
            if (sb.mem_ack) begin
               state_nxt = RD_DONE;
               mem_req_d = 1'b0;
               rdata_d   = sb.mem_rdata;
            end
         end
         RD_DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_wstrobe_q <= '0;
         rdata_q       <= '0;
      end else begin
         state         <= state_nxt;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_wstrobe_q <= mem_wstrobe_d;
         rdata_q       <= rdata_d;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) begin
         ent_addr[tail] <= sb.req_addr[31:2];
         ent_data[tail] <= sb.req_wdata;
         ent_strb[tail] <= sb.req_wstrobe;
      end
   end

   assign sb.mem_req     = mem_req_q;
   assign sb.mem_we      = mem_we_q;
   assign sb.mem_addr    = mem_addr_q;
   assign sb.mem_wdata   = mem_wdata_q;
   assign sb.mem_wstrobe = mem_wstrobe_q;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed bench for store_buffer (DEPTH=4), assertion checks per step
module tb_store_buffer;
   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   store_buffer_if sb_if ();

   store_buffer #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
      sb_if.req_wen     = wen;
      sb_if.req_ren     = ren;
      sb_if.req_addr    = addr;
      sb_if.req_wdata   = wdata;
      sb_if.req_wstrobe = strb;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      sb_if.mem_ack   = 1'b0;
      sb_if.mem_rdata = '0;
      drive(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      cyc();
      cyc();
      check("rst_mem_req", sb_if.mem_req, 0);
      check("rst_mem_we", sb_if.mem_we, 0);
      check("rst_mem_addr", sb_if.mem_addr, 0);
      check("rst_mem_wdata", sb_if.mem_wdata, 0);
      check("rst_mem_wstrobe", sb_if.mem_wstrobe, 0);
      check("rst_resp", sb_if.resp_rdata, 0);
      #1 check("rst_stall", sb_if.stall, 0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b1;
      #1 check("idle_stall", sb_if.stall, 0);
      cyc();

      // Store fill with memory stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h100 + 4 * i, 32'hA0A0_0000 + i, 4'hF);
         #1 check("fill_stall", sb_if.stall, 0);
         cyc();
      end
      drive(1'b1, 1'b0, 32'h110, 32'hA0A0_0004, 4'hF);
      #1 check("fill_stall5", sb_if.stall, 1);
      check("fill_mem_req", sb_if.mem_req, 1);
      check("fill_mem_we", sb_if.mem_we, 1);
      check("fill_mem_addr", sb_if.mem_addr, 32'h100);
      check("fill_mem_wdata", sb_if.mem_wdata, 32'hA0A0_0000);
      cyc();
      #1 check("fill_stall_hold", sb_if.stall, 1);
      check("fill_addr_hold", sb_if.mem_addr, 32'h100);

      // Drain
      sb_if.mem_ack = 1'b1;
      #1 check("drain_full_pop_stall", sb_if.stall, 1);
      cyc();
      check("drain_req_drop", sb_if.mem_req, 0);
      #1 check("drain_accept5", sb_if.stall, 0);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 1; i <= 4; i++) begin
         check("drain_req", sb_if.mem_req, 1);
         check("drain_addr", sb_if.mem_addr, 32'h100 + 4 * i);
         check("drain_wdata", sb_if.mem_wdata, 32'hA0A0_0000 + i);
         cyc();
         check("drain_req_gap", sb_if.mem_req, 0);
         cyc();
      end
      check("drain_empty", sb_if.mem_req, 0);
      sb_if.mem_ack = 1'b0;

      // Load miss
      drive(1'b0, 1'b1, 32'h200, 32'h0, 4'h0);
      #1 check("ld_stall1", sb_if.stall, 1);
      cyc();
      check("ld_mem_req", sb_if.mem_req, 1);
      check("ld_mem_we", sb_if.mem_we, 0);
      check("ld_mem_addr", sb_if.mem_addr, 32'h200);
      check("ld_mem_strobe", sb_if.mem_wstrobe, 32'hF);
      sb_if.mem_ack   = 1'b1;
      sb_if.mem_rdata = 32'hDEAD_BEEF;
      #1 check("ld_stall2", sb_if.stall, 1);
      cyc();
      sb_if.mem_ack = 1'b0;
      check("ld_req_drop", sb_if.mem_req, 0);
      #1 check("ld_stall_done", sb_if.stall, 0);
      check("ld_rdata", sb_if.resp_rdata, 32'hDEAD_BEEF);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cyc();

      // Partial-strobe conflict
      drive(1'b1, 1'b0, 32'h300, 32'h0000_0055, 4'h1);
      cyc();
      drive(1'b0, 1'b1, 32'h302, 32'h0, 4'h0);
      #1 check("cf_stall", sb_if.stall, 1);
      cyc();
      check("cf_wr_req", sb_if.mem_req, 1);
      check("cf_wr_we", sb_if.mem_we, 1);
      check("cf_wr_addr", sb_if.mem_addr, 32'h300);
      check("cf_wr_strobe", sb_if.mem_wstrobe, 32'h1);
      sb_if.mem_ack = 1'b1;
      cyc();
      sb_if.mem_ack = 1'b0;
      check("cf_wr_drop", sb_if.mem_req, 0);
      cyc();
      check("cf_rd_req", sb_if.mem_req, 1);
      check("cf_rd_we", sb_if.mem_we, 0);
      check("cf_rd_addr", sb_if.mem_addr, 32'h302);
      sb_if.mem_ack   = 1'b1;
      sb_if.mem_rdata = 32'h1234_5678;
      cyc();
      sb_if.mem_ack = 1'b0;
      #1 check("cf_stall_done", sb_if.stall, 0);
      check("cf_rdata", sb_if.resp_rdata, 32'h1234_5678);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cyc();

      // Full-strobe match: forwarded or treated as conflict
      drive(1'b1, 1'b0, 32'h400, 32'h1111_1111, 4'hF);
      cyc();
      drive(1'b1, 1'b0, 32'h400, 32'h2222_2222, 4'hF);
      cyc();
      drive(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
      #1;
`ifdef SB_FORWARD_EN
      check("fw_stall", sb_if.stall, 0);
      check("fw_rdata", sb_if.resp_rdata, 32'h2222_2222);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`else
      check("fw_stall", sb_if.stall, 1);
`endif
      check("fw_wr1_req", sb_if.mem_req, 1);
      check("fw_wr1_we", sb_if.mem_we, 1);
      check("fw_wr1_addr", sb_if.mem_addr, 32'h400);
      check("fw_wr1_data", sb_if.mem_wdata, 32'h1111_1111);
      sb_if.mem_ack = 1'b1;
      cyc();
      sb_if.mem_ack = 1'b0;
      check("fw_wr1_drop", sb_if.mem_req, 0);
      cyc();
      check("fw_wr2_we", sb_if.mem_we, 1);
      check("fw_wr2_data", sb_if.mem_wdata, 32'h2222_2222);
      sb_if.mem_ack = 1'b1;
      cyc();
      sb_if.mem_ack = 1'b0;
      check("fw_wr2_drop", sb_if.mem_req, 0);
`ifndef SB_FORWARD_EN
      cyc();
      check("fw_rd_req", sb_if.mem_req, 1);
      check("fw_rd_we", sb_if.mem_we, 0);
      check("fw_rd_addr", sb_if.mem_addr, 32'h400);
      sb_if.mem_ack   = 1'b1;
      sb_if.mem_rdata = 32'h2222_2222;
      cyc();
      sb_if.mem_ack = 1'b0;
      #1 check("fw_rd_stall", sb_if.stall, 0);
      check("fw_rd_rdata", sb_if.resp_rdata, 32'h2222_2222);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`endif
      cyc();

      // Reset in the middle of a write
      drive(1'b1, 1'b0, 32'h500, 32'h5050_5050, 4'hF);
      cyc();
      drive(1'b1, 1'b0, 32'h504, 32'h5454_5454, 4'hF);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("mr_wr_req", sb_if.mem_req, 1);
      check("mr_wr_addr", sb_if.mem_addr, 32'h500);
      rst = 1'b0;
      cyc();
      check("mr_req_drop", sb_if.mem_req, 0);
      check("mr_addr_clr", sb_if.mem_addr, 0);
      rst = 1'b1;
      sb_if.mem_ack = 1'b1;
      cyc();
      sb_if.mem_ack = 1'b0;
      check("mr_late_ack", sb_if.mem_req, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h600 + 4 * i, 32'h6000_0000 + i, 4'hF);
         #1 check("mr_refill_stall", sb_if.stall, 0);
         cyc();
      end
      drive(1'b1, 1'b0, 32'h610, 32'h6000_0004, 4'hF);
      #1 check("mr_refill_full", sb_if.stall, 1);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
